// File: rtl/mux16_rr_sched_pkg.sv
// Shared types and constants for the 16-way round-robin mux scheduler.
package mux16_rr_sched_pkg;

  localparam int unsigned NREQ  = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_16x1.sv
// 16:1 multiplexer of W-bit operands.
module mux_16x1 #(
  parameter int unsigned W = 64
) (
  input  logic [3:0]   sel,
  input  logic [W-1:0] d0,  input logic [W-1:0] d1,  input logic [W-1:0] d2,  input logic [W-1:0] d3,
  input  logic [W-1:0] d4,  input logic [W-1:0] d5,  input logic [W-1:0] d6,  input logic [W-1:0] d7,
  input  logic [W-1:0] d8,  input logic [W-1:0] d9,  input logic [W-1:0] d10, input logic [W-1:0] d11,
  input  logic [W-1:0] d12, input logic [W-1:0] d13, input logic [W-1:0] d14, input logic [W-1:0] d15,
  output logic [W-1:0] y
);

  always_comb begin
    unique case (sel)
      4'd0:    y = d0;
      4'd1:    y = d1;
      4'd2:    y = d2;
      4'd3:    y = d3;
      4'd4:    y = d4;
      4'd5:    y = d5;
      4'd6:    y = d6;
      4'd7:    y = d7;
      4'd8:    y = d8;
      4'd9:    y = d9;
      4'd10:   y = d10;
      4'd11:   y = d11;
      4'd12:   y = d12;
      4'd13:   y = d13;
      4'd14:   y = d14;
      default: y = d15;
    endcase
  end

endmodule

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set bit of req scanning from ptr upward with wrap.
module rr_pick16
  import mux16_rr_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 64-bit 16:1 mux between 16 requesters,
// with a single-entry valid/ready output register.
module mux16_rr_sched
  import mux16_rr_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      i0,  input logic [63:0] i1,  input logic [63:0] i2,  input logic [63:0] i3,
  input  logic [63:0]      i4,  input logic [63:0] i5,  input logic [63:0] i6,  input logic [63:0] i7,
  input  logic [63:0]      i8,  input logic [63:0] i9,  input logic [63:0] i10, input logic [63:0] i11,
  input  logic [63:0]      i12, input logic [63:0] i13, input logic [63:0] i14, input logic [63:0] i15,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, sel_q, win;
  logic             any, grant, hshake;
  logic [63:0]      mux_y;

  rr_pick16 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // The mux select follows the winner combinationally so the capture happens in the grant cycle.
  mux_16x1 #(.W(64)) u_mux (
    .sel (sel),
    .d0 (i0),  .d1 (i1),  .d2 (i2),  .d3 (i3),
    .d4 (i4),  .d5 (i5),  .d6 (i6),  .d7 (i7),
    .d8 (i8),  .d9 (i9),  .d10(i10), .d11(i11),
    .d12(i12), .d13(i13), .d14(i14), .d15(i15),
    .y  (mux_y)
  );

  assign grant  = (state == ST_IDLE) && any;
  assign hshake = (state == ST_BUSY) && out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    sel       = sel_q;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          gnt       = onehot16(win);
          sel       = win;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (out_valid && out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      sel_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr       <= win + 4'd1;
        sel_q     <= win;
        out_data  <= mux_y;
        out_valid <= 1'b1;
      end
      if (hshake) begin
        out_valid  <= 1'b0;
        xfer_count <= xfer_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed self-checking bench for mux16_rr_sched.
module tb_mux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] opd [16];
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_count;

  int checks = 0;
  int errors = 0;
  int exp_xfer = 0;

  typedef struct {
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  sel;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  mux16_rr_sched #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0(opd[0]),   .i1(opd[1]),   .i2(opd[2]),   .i3(opd[3]),
    .i4(opd[4]),   .i5(opd[5]),   .i6(opd[6]),   .i7(opd[7]),
    .i8(opd[8]),   .i9(opd[9]),   .i10(opd[10]), .i11(opd[11]),
    .i12(opd[12]), .i13(opd[13]), .i14(opd[14]), .i15(opd[15]),
    .req(req), .gnt(gnt), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_xfer", 64'(xfer_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_xfer = 0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) opd[k] = 64'hDEAD_BEEF_0000_0000 | 64'(k);
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b1;

    tbl[0]  = '{16'h0010, 16'h0010, 4'd4};
    tbl[1]  = '{16'h0030, 16'h0020, 4'd5};
    tbl[2]  = '{16'h0001, 16'h0001, 4'd0};
    tbl[3]  = '{16'h8004, 16'h0004, 4'd2};
    tbl[4]  = '{16'h0004, 16'h0004, 4'd2};
    tbl[5]  = '{16'h0004, 16'h0004, 4'd2};
    tbl[6]  = '{16'h4000, 16'h4000, 4'd14};
    tbl[7]  = '{16'h8001, 16'h8000, 4'd15};
    tbl[8]  = '{16'h8001, 16'h0001, 4'd0};
    tbl[9]  = '{16'h8001, 16'h8000, 4'd15};
    tbl[10] = '{16'h0000, 16'h0000, 4'd15};
    tbl[11] = '{16'h1000, 16'h1000, 4'd12};

    // Reset state, then idle with no requests.
    #2;
    chk("rst_data", out_data, 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("idle_gnt", 64'(gnt), 64'd0);
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_xfer", 64'(xfer_count), 64'd0);
    end

    // Table: one arbitration + handshake per entry, pointer carried across entries.
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      req = tbl[n].req;
      out_ready = 1'b1;
      #1;
      chk($sformatf("tbl%0d_gnt", n), 64'(gnt), 64'(tbl[n].gnt));
      chk($sformatf("tbl%0d_sel", n), 64'(sel), 64'(tbl[n].sel));
      @(posedge clk);
      @(negedge clk);
      if (tbl[n].gnt != 16'h0) begin
        chk($sformatf("tbl%0d_valid", n), 64'(out_valid), 64'd1);
        chk($sformatf("tbl%0d_data", n), out_data, 64'hDEAD_BEEF_0000_0000 | 64'(tbl[n].sel));
        chk($sformatf("tbl%0d_busygnt", n), 64'(gnt), 64'd0);
        req = '0;
        @(posedge clk);
        exp_xfer++;
        @(negedge clk);
      end
      chk($sformatf("tbl%0d_vdrop", n), 64'(out_valid), 64'd0);
      chk($sformatf("tbl%0d_xfer", n), 64'(xfer_count), 64'(exp_xfer));
      req = '0;
    end

    // All 16 requesting from a fresh pointer: rotation on alternating cycles.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      logic [15:0] e;
      e = (c % 2 == 0) ? (16'h1 << ((c / 2) % 16)) : 16'h0;
      if (c != 0) @(negedge clk);
      req = 16'hFFFF;
      out_ready = 1'b1;
      #1;
      chk($sformatf("rot%0d_gnt", c), 64'(gnt), 64'(e));
    end
    @(negedge clk);
    req = '0;
    exp_xfer = 20;
    chk("rot_xfer", 64'(xfer_count), 64'(exp_xfer));

    // Backpressure: output held stable while req and i3 wiggle.
    @(negedge clk);
    req = 16'h0008;
    out_ready = 1'b0;
    #1;
    chk("stall_gnt", 64'(gnt), 64'h0008);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = (c % 2 == 0) ? 16'hFFFF : 16'h0008;
      opd[3] = {$urandom, $urandom};
      #1;
      chk($sformatf("stall%0d_data", c), out_data, 64'hDEAD_BEEF_0000_0003);
      chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_gnt", c), 64'(gnt), 64'd0);
    end
    @(negedge clk);
    req = '0;
    opd[3] = 64'hDEAD_BEEF_0000_0003;
    out_ready = 1'b1;
    @(negedge clk);
    exp_xfer++;
    chk("stall_done_valid", 64'(out_valid), 64'd0);
    chk("stall_done_xfer", 64'(xfer_count), 64'(exp_xfer));
    @(negedge clk);
    chk("stall_once_xfer", 64'(xfer_count), 64'(exp_xfer));

    // Asynchronous reset in BUSY, with the pointer left away from zero.
    @(negedge clk);
    req = 16'h0020;
    out_ready = 1'b0;
    @(negedge clk);
    req = '0;
    #1;
    chk("arst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_xfer", 64'(xfer_count), 64'd0);
    chk("arst_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 16'h0041;
    out_ready = 1'b1;
    #1;
    chk("arst_ptr_gnt", 64'(gnt), 64'h0001);
    @(negedge clk);
    chk("arst_cap_data", out_data, 64'hDEAD_BEEF_0000_0000);
    chk("arst_cap_valid", 64'(out_valid), 64'd1);
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
